smi_stream_ctrl: RTL and testbench
==================================

# smi_stream_ctrl

Parametrised SMI read-stream controller: serialises WORD_W-bit samples from NUM_CH channel FIFOs onto the 8-bit Raspberry Pi SMI bus, one byte per SOE strobe, MSB byte first. It sits between the per-channel RX FIFOs and the SMI pins, and answers the module register bus (ioc fetch). It adds refill-on-demand, underrun detection, strobe synchronisation and a per-channel test-counter mode.

## Interface
- NUM_CH, 2, number of read channels, 1..3.
- WORD_W, 32, FIFO word width; multiple of 8, 16..64.
- MODULE_VER, 8'h02, value returned at ioc 0.
- i_sys_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ioc  in  5  register address.
- i_cs, i_fetch_cmd  in  1 each  register read qualifier; a read occurs when both are 1.
- o_data_out  out  8  register read data.
- o_fifo_pull  out  NUM_CH  one-cycle pull pulse per channel.
- i_fifo_data  in  NUM_CH*WORD_W  channel c at [c*WORD_W +: WORD_W]; valid the cycle after the pull.
- i_fifo_empty, i_fifo_full  in  NUM_CH each  FIFO flags.
- i_smi_a  in  3  SMI address.
- i_smi_soe_se  in  1  async SOE strobe, active low.
- i_smi_test  in  1  test-pattern mode.
- o_smi_data_out  out  8  byte presented to SMI.
- o_smi_read_req  out  1  OR of ~i_fifo_empty, OR i_smi_test.
- o_smi_writing  out  1  equals i_smi_a[2].
- o_address_error  out  1  sticky bad-address flag.

## Operation
- Channel c is read at SMI address 3'b101+c. Address 3'b000 is idle. Any other address sets o_address_error and drives o_smi_data_out=0.
- SOE passes through a 2-flop synchroniser and a registered edge detector. A strobe end is a synchronised 0->1 transition.
- Shared FSM with byte index idx (width clog2(WORD_W/8)):
  - EMPTY: if the selected channel is non-empty and not in test mode, go to PULL.
  - PULL: o_fifo_pull[c]=1 for exactly one cycle, then go to LATCH.
  - LATCH: capture i_fifo_data slice into the holding register, set idx=0, go to READY.
  - READY: o_smi_data_out = hold[WORD_W-1-8*idx -: 8], registered. On a strobe end, if idx is the last byte go to EMPTY, else idx+1.
- Underrun: a strobe end in any state other than READY (non-test) sets the underrun flag. o_smi_data_out is driven 0x00 during underrun.
- Address change between valid channels, or to idle or invalid, returns the FSM to EMPTY. The partial word is dropped and no extra pull occurs. A pull already issued still completes LATCH, then is discarded on the change.
- Test mode: no FIFO pulls. Each channel has an 8-bit counter, output on strobe end, then incremented; it wraps at 255->0.
- Registers, read on the cycle after the fetch:
  - ioc 0: MODULE_VER.
  - ioc 1: [2c]=empty[c], [2c+1]=full[c], unused bits 0, [6]=underrun, [7]=address error.
  - Reading ioc 1 clears both sticky flags. If a set event occurs in the same cycle, set wins.
  - Unknown ioc: o_data_out holds its value.

## Timing
- Reset values: o_data_out=0, o_smi_data_out=0, o_fifo_pull=0, o_address_error=0. FSM=EMPTY, idx=0, test counters=0, synchroniser=1 (SOE idle high).
- Strobe end at the pin to the next byte on o_smi_data_out: 3 cycles (2 sync, 1 register).
- Refill: EMPTY->PULL->LATCH->READY is 3 cycles. The first byte is valid 1 cycle after READY is entered.
- Reset asserted mid-word aborts immediately. Any in-flight FIFO word is lost.

## Configuration
- SMI_STREAM_STATS_EN defined:
  - Adds an 8-bit underrun counter, readable at ioc 2.
  - The counter saturates at 255 and clears on read. An increment in the same cycle as the read gives 1.
- SMI_STREAM_STATS_EN undefined: ioc 2 reads 0x00 and no counter logic is built.

## Test plan
- Channel 0 FIFO holds 32'hA1B2C3D4, address 3'b101, 4 strobes -> bytes A1, B2, C3, D4 in order. Exactly one pull on o_fifo_pull[0].
- Two words queued, 8 strobes -> 8 bytes in order with exactly 2 pulls. Underrun stays 0.
- FIFO empty, 1 strobe -> output 0x00 and ioc 1 bit 6 = 1. The next ioc 1 read returns bit 6 = 0.
- i_smi_test=1, address 3'b110, 258 strobes -> sequence 00..FF, 00, 01 and no pulls.
- Address 3'b011 -> o_address_error=1 and data 0x00. Status read clears it unless 3'b011 is still present.
- With SMI_STREAM_STATS_EN defined, 300 underrun strobes -> ioc 2 reads 0xFF, then 0x00 on the second read.

Source files
------------

// File: rtl/smi_stream_ctrl.sv
// rtl/smi_stream_ctrl.sv - SMI read-stream controller: channel FIFO words out as SMI bytes
//
// Serialises WORD_W-bit words from NUM_CH channel FIFOs onto the 8-bit SMI
// bus, MSB byte first, one byte per SOE strobe. The controller refills on
// demand, flags underruns and bad addresses, and has a per-channel
// test-counter mode.
//
// Optional feature: define SMI_STREAM_STATS_EN to add an 8-bit saturating
// underrun counter at ioc 2 that clears when read.
//
// Ports:
//   i_sys_clk, i_reset        clock, synchronous active-high reset
//   i_ioc, i_cs, i_fetch_cmd  register read address and qualifiers
//   o_data_out                register read data, one cycle after the fetch
//   o_fifo_pull               one-cycle pull pulse per channel
//   i_fifo_data               channel words, valid the cycle after the pull
//   i_fifo_empty, i_fifo_full per-channel FIFO flags
//   i_smi_a                   SMI address (3'b101 + c selects channel c)
//   i_smi_soe_se              asynchronous SOE strobe, active low
//   i_smi_test                test-counter mode
//   o_smi_data_out            byte presented to SMI
//   o_smi_read_req            data available, or test mode
//   o_smi_writing             i_smi_a[2]
//   o_address_error           sticky bad-address flag
module smi_stream_ctrl #(
  parameter int         NUM_CH     = 2,
  parameter int         WORD_W     = 32,
  parameter logic [7:0] MODULE_VER = 8'h02
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset,
  input  logic [4:0]               i_ioc,
  input  logic                     i_cs,
  input  logic                     i_fetch_cmd,
  output logic [7:0]               o_data_out,
  output logic [NUM_CH-1:0]        o_fifo_pull,
  input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
  input  logic [NUM_CH-1:0]        i_fifo_empty,
  input  logic [NUM_CH-1:0]        i_fifo_full,
  input  logic [2:0]               i_smi_a,
  input  logic                     i_smi_soe_se,
  input  logic                     i_smi_test,
  output logic [7:0]               o_smi_data_out,
  output logic                     o_smi_read_req,
  output logic                     o_smi_writing,
  output logic                     o_address_error
);

  localparam int NBYTES = WORD_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_EMPTY, S_PULL, S_LATCH, S_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] hold;
  logic [1:0]        cur_ch;
  logic              drop;
  logic [2:0]        a_q;
  logic              soe_s1, soe_s2, soe_d;
  logic              underrun;
  logic [7:0]        tcnt [NUM_CH];

  logic              sel_valid, sel_idle, sel_bad, sel_empty;
  logic [1:0]        sel_ch;
  logic              strobe_end, a_chg, ur_evt, rd, rd_stat;
  logic [IDX_W-1:0]  idx_inc;
  logic [7:0]        cur_byte, nxt_byte, sel_cnt, status, stats_rd;
  logic [WORD_W-1:0] fifo_word;

  assign o_smi_read_req = (|(~i_fifo_empty)) | i_smi_test;
  assign o_smi_writing  = i_smi_a[2];

  // A strobe end is the rising edge of the synchronised SOE.
  assign strobe_end = soe_s2 & ~soe_d;
  // Any address change, including to idle or invalid, abandons the current word.
  assign a_chg      = (i_smi_a != a_q);
  assign ur_evt     = strobe_end && !i_smi_test && (state != S_READY);
  assign rd         = i_cs & i_fetch_cmd;
  assign rd_stat    = rd && (i_ioc == 5'd1);
  assign idx_inc    = idx + 1'b1;

  always_comb begin
    sel_idle  = (i_smi_a == 3'd0);
    sel_valid = (i_smi_a >= 3'd5) && (int'(i_smi_a) < 5 + NUM_CH);
    sel_bad   = !sel_idle && !sel_valid;
    sel_ch    = 2'(i_smi_a - 3'd5);
    sel_empty = 1'b1;
    sel_cnt   = 8'h00;
    fifo_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 2'(c)) begin
        sel_empty = i_fifo_empty[c];
        sel_cnt   = tcnt[c];
      end
      if (cur_ch == 2'(c)) fifo_word = i_fifo_data[c*WORD_W +: WORD_W];
    end
  end

  // cur_byte is the byte at idx; nxt_byte is the one a strobe end advances to,
  // so the output register updates in the same cycle idx does.
  always_comb begin
    cur_byte = hold[WORD_W-1 -: 8];
    nxt_byte = hold[WORD_W-1 -: 8];
    for (int b = 0; b < NBYTES; b++) begin
      if (idx == IDX_W'(b))     cur_byte = hold[WORD_W-1-8*b -: 8];
      if (idx_inc == IDX_W'(b)) nxt_byte = hold[WORD_W-1-8*b -: 8];
    end
  end

  always_comb begin
    status = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      status[2*c]   = i_fifo_empty[c];
      status[2*c+1] = i_fifo_full[c];
    end
    status[6] = underrun;
    status[7] = o_address_error;
  end

`ifdef SMI_STREAM_STATS_EN
  logic [7:0] ur_cnt;

  // Clear-on-read counter; an underrun in the read cycle itself counts as 1.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset)
      ur_cnt <= 8'h00;
    else if (rd && (i_ioc == 5'd2))
      ur_cnt <= {7'd0, ur_evt};
    else if (ur_evt && (ur_cnt != 8'hFF))
      ur_cnt <= ur_cnt + 8'd1;
  end

  assign stats_rd = ur_cnt;
`else
  assign stats_rd = 8'h00;
`endif

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state           <= S_EMPTY;
      idx             <= '0;
      hold            <= '0;
      cur_ch          <= '0;
      drop            <= 1'b0;
      a_q             <= '0;
      soe_s1          <= 1'b1;
      soe_s2          <= 1'b1;
      soe_d           <= 1'b1;
      underrun        <= 1'b0;
      o_address_error <= 1'b0;
      o_smi_data_out  <= 8'h00;
      o_fifo_pull     <= '0;
      o_data_out      <= 8'h00;
      for (int c = 0; c < NUM_CH; c++) tcnt[c] <= 8'h00;
    end else begin
      soe_s1 <= i_smi_soe_se;
      soe_s2 <= soe_s1;
      soe_d  <= soe_s2;
      a_q    <= i_smi_a;

      // Sticky flags: a set event in a status-read cycle wins over the clear.
      underrun        <= ur_evt  | (underrun        & ~rd_stat);
      o_address_error <= sel_bad | (o_address_error & ~rd_stat);

      o_fifo_pull <= '0;
      case (state)
        S_EMPTY: begin
          if (sel_valid && !a_chg && !sel_empty && !i_smi_test) begin
            state  <= S_PULL;
            cur_ch <= sel_ch;
            drop   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) o_fifo_pull[c] <= (sel_ch == 2'(c));
          end
        end
        S_PULL: begin
          // The pull is already out; let the word land, then discard it.
          state <= S_LATCH;
          if (a_chg) drop <= 1'b1;
        end
        S_LATCH: begin
          hold  <= fifo_word;
          idx   <= '0;
          drop  <= 1'b0;
          state <= (drop || a_chg) ? S_EMPTY : S_READY;
        end
        default: begin
          if (a_chg || i_smi_test) begin
            state <= S_EMPTY;
          end else if (strobe_end) begin
            if (idx == LAST_IDX) state <= S_EMPTY;
            else                 idx   <= idx_inc;
          end
        end
      endcase

      for (int c = 0; c < NUM_CH; c++)
        if (i_smi_test && sel_valid && strobe_end && (sel_ch == 2'(c)))
          tcnt[c] <= tcnt[c] + 8'd1;

      if (!sel_valid)
        o_smi_data_out <= 8'h00;
      else if (i_smi_test) begin
        if (strobe_end) o_smi_data_out <= sel_cnt;
      end else if ((state == S_READY) && !a_chg) begin
        if (!strobe_end)           o_smi_data_out <= cur_byte;
        else if (idx == LAST_IDX)  o_smi_data_out <= 8'h00;
        else                       o_smi_data_out <= nxt_byte;
      end else if (strobe_end)
        o_smi_data_out <= 8'h00;

      if (rd) begin
        case (i_ioc)
          5'd0:    o_data_out <= MODULE_VER;
          5'd1:    o_data_out <= status;
          5'd2:    o_data_out <= stats_rd;
          default: o_data_out <= o_data_out;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smi_stream_ctrl.sv
// tb/tb_smi_stream_ctrl.sv - self-checking bench for smi_stream_ctrl
module tb_smi_stream_ctrl;
  localparam int NUM_CH = 2;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [4:0]               ioc;
  logic                     cs, fetch;
  logic [7:0]               data_out;
  logic [NUM_CH-1:0]        fifo_pull;
  logic [NUM_CH*WORD_W-1:0] fifo_data = '0;
  logic [NUM_CH-1:0]        fifo_empty, fifo_full;
  logic [2:0]               smi_a;
  logic                     soe, smi_test;
  logic [7:0]               smi_data;
  logic                     read_req, writing, addr_err;

  always #5 clk = ~clk;

  smi_stream_ctrl #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .MODULE_VER(8'h02)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_ioc(ioc), .i_cs(cs), .i_fetch_cmd(fetch),
    .o_data_out(data_out), .o_fifo_pull(fifo_pull), .i_fifo_data(fifo_data),
    .i_fifo_empty(fifo_empty), .i_fifo_full(fifo_full), .i_smi_a(smi_a),
    .i_smi_soe_se(soe), .i_smi_test(smi_test), .o_smi_data_out(smi_data),
    .o_smi_read_req(read_req), .o_smi_writing(writing), .o_address_error(addr_err)
  );

  // Behavioural channel FIFOs: a pull pops the head, which appears the next cycle.
  logic [WORD_W-1:0] fq [NUM_CH][$];
  int pulls [NUM_CH];
  logic [7:0] tm [NUM_CH];
  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (fifo_pull[c]) begin
        pulls[c] = pulls[c] + 1;
        if (fq[c].size() > 0) fifo_data[c*WORD_W +: WORD_W] <= fq[c].pop_front();
      end
      fifo_empty[c] <= (fq[c].size() == 0);
      fifo_full[c]  <= (fq[c].size() >= DEPTH);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe();
    soe = 1'b0;
    tick(2);
    soe = 1'b1;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [7:0] v);
    ioc = a; cs = 1'b1; fetch = 1'b1;
    tick(1);
    cs = 1'b0; fetch = 1'b0;
    v = data_out;
  endtask

  function automatic logic [7:0] exp_status(input logic ur, input logic ae);
    logic [7:0] s;
    s = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      s[2*c]   = (fq[c].size() == 0);
      s[2*c+1] = (fq[c].size() >= DEPTH);
    end
    s[6] = ur;
    s[7] = ae;
    return s;
  endfunction

  // Streams the given words out of channel c; every byte is checked before
  // its strobe, and 2 and 3 cycles after each strobe end.
  task automatic run_stream(input int c, input logic [WORD_W-1:0] words[$], input string tag);
    logic [7:0] eb[$];
    logic [7:0] nxt;
    int p0;
    p0 = pulls[c];
    smi_a = 3'(5 + c);
    foreach (words[i]) begin
      fq[c].push_back(words[i]);
      for (int b = WORD_W/8 - 1; b >= 0; b--) eb.push_back(words[i][8*b +: 8]);
    end
    foreach (eb[k]) begin
      tick(8);
      check_eq({tag, "_byte"}, smi_data, eb[k]);
      strobe();
      nxt = (((k + 1) % (WORD_W/8)) == 0) ? 8'h00 : eb[k+1];
      tick(2);
      check_eq({tag, "_hold"}, smi_data, eb[k]);
      tick(1);
      check_eq({tag, "_lat3"}, smi_data, nxt);
    end
    tick(8);
    check_eq({tag, "_pulls"}, 64'(pulls[c] - p0), 64'(words.size()));
  endtask

  initial begin
    logic [WORD_W-1:0] wq[$];
    logic [WORD_W-1:0] w1, w2;
    logic [7:0] v;
    int p0, p1;

    rst = 1'b1; ioc = '0; cs = 1'b0; fetch = 1'b0; smi_a = 3'd0; soe = 1'b1; smi_test = 1'b0;
    for (int c = 0; c < NUM_CH; c++) tm[c] = 8'h00;
    tick(4);
    rst = 1'b0;
    tick(1);
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_smi_data", smi_data, 8'h00);
    check_eq("rst_pull", fifo_pull, '0);
    check_eq("rst_addr_err", addr_err, 1'b0);
    check_eq("rst_read_req", read_req, 1'b0);

    reg_read(5'd0, v);
    check_eq("ioc0_ver", v, 8'h02);
    reg_read(5'd9, v);
    check_eq("ioc_unknown_holds", v, 8'h02);

    wq = {32'hA1B2C3D4};
    run_stream(0, wq, "word1");

    wq = {$urandom(), $urandom()};
    run_stream(0, wq, "word2");

    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(0, NUM_CH - 1);
      wq = {};
      for (int i = 0; i < $urandom_range(1, 3); i++) wq.push_back($urandom());
      run_stream(c, wq, "rand");
    end

    reg_read(5'd1, v);
    check_eq("status_no_ur", v, exp_status(1'b0, 1'b0));

    // Leaving a channel mid-word drops the rest of it without an extra pull.
    w1 = $urandom(); w2 = $urandom();
    p0 = pulls[0];
    fq[0].push_back(w1); fq[0].push_back(w2);
    smi_a = 3'b101;
    tick(8);
    check_eq("drop_b0", smi_data, w1[31:24]);
    check_eq("read_req", read_req, 1'b1);
    strobe();
    tick(8);
    check_eq("drop_b1", smi_data, w1[23:16]);
    smi_a = 3'b110;
    tick(4);
    smi_a = 3'b101;
    tick(8);
    check_eq("drop_next_word", smi_data, w2[31:24]);
    check_eq("drop_pulls", 64'(pulls[0] - p0), 64'd2);

    // Test-counter mode on channel 1.
    smi_test = 1'b1;
    smi_a = 3'b110;
    p0 = pulls[0]; p1 = pulls[1];
    tick(4);
    for (int i = 0; i < 258; i++) begin
      strobe();
      tick(4);
      check_eq("test_cnt", smi_data, tm[1]);
      tm[1] = tm[1] + 8'd1;
    end
    check_eq("test_no_pulls", 64'(pulls[0] + pulls[1] - p0 - p1), 64'd0);
    smi_test = 1'b0;
    reg_read(5'd1, v);
    check_eq("test_no_ur", v[6], 1'b0);

    // Underrun on an empty channel.
    smi_a = 3'b101;
    tick(4);
    strobe();
    tick(4);
    check_eq("ur_data", smi_data, 8'h00);
    reg_read(5'd1, v);
    check_eq("ur_status", v, exp_status(1'b1, 1'b0));
    reg_read(5'd1, v);
    check_eq("ur_cleared", v[6], 1'b0);

    // Invalid addresses.
    smi_a = 3'b011;
    tick(3);
    check_eq("ae_flag", addr_err, 1'b1);
    check_eq("ae_data", smi_data, 8'h00);
    check_eq("ae_writing", writing, 1'b0);
    reg_read(5'd1, v);
    check_eq("ae_status", v[7], 1'b1);
    tick(1);
    check_eq("ae_still_set", addr_err, 1'b1);
    smi_a = 3'b111;
    tick(2);
    check_eq("ae_writing_hi", writing, 1'b1);
    check_eq("ae_111", addr_err, 1'b1);
    smi_a = 3'b000;
    tick(2);
    check_eq("ae_sticky", addr_err, 1'b1);
    reg_read(5'd1, v);
    check_eq("ae_status2", v[7], 1'b1);
    tick(1);
    check_eq("ae_clear", addr_err, 1'b0);

`ifdef SMI_STREAM_STATS_EN
    smi_a = 3'b101;
    tick(4);
    for (int i = 0; i < 300; i++) begin
      strobe();
      tick(4);
    end
    reg_read(5'd2, v);
    check_eq("stats_sat", v, 8'hFF);
    reg_read(5'd2, v);
    check_eq("stats_clr", v, 8'h00);
`else
    reg_read(5'd2, v);
    check_eq("stats_off", v, 8'h00);
`endif

    // Reset mid-word loses the word.
    smi_a = 3'b101;
    fq[0].push_back($urandom());
    tick(8);
    strobe();
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check_eq("midrst_data", smi_data, 8'h00);
    check_eq("midrst_pull", fifo_pull, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
